// File: rtl/ofifo_drain_ctrl.sv
// Lockstep drain of a column-FIFO bank into a single-port SRAM, one row per write.
// Optional replay/flush path is compiled in with `define DRAIN_REPLAY_EN.
module ofifo_drain_ctrl #(
  parameter int col    = 8,
  parameter int addr_w = 11,
  parameter int cnt_w  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_w-1:0]  len,
  input  logic [addr_w-1:0] base_addr,
  input  logic [col-1:0]    fifo_empty,
`ifdef DRAIN_REPLAY_EN
  input  logic              replay,
`endif
  output logic              fifo_rd,
  output logic              fifo_flush,
  output logic              sram_cen,
  output logic              sram_wen,
  output logic [addr_w-1:0] sram_addr,
  output logic              busy,
  output logic              done,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef DRAIN_REPLAY_EN
  localparam logic [1:0] S_FLUSH = 2'd3;
`endif

  logic [1:0]        state_q, state_d;
  logic [cnt_w-1:0]  len_q, len_d;
  logic [cnt_w-1:0]  row_q, row_d;
  logic [addr_w-1:0] base_q, base_d;
  logic [15:0]       stall_q, stall_d;
  logic              all_valid;

  assign all_valid = ~|fifo_empty;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    row_d   = row_q;
    base_d  = base_q;
    stall_d = stall_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          base_d  = base_addr;
          row_d   = '0;
          stall_d = '0;
          state_d = (len == '0) ? S_DONE : S_READ;
        end
`ifdef DRAIN_REPLAY_EN
        else if (replay) begin
          // Replay keeps the previous length; only the destination moves.
          base_d  = base_addr;
          row_d   = '0;
          stall_d = '0;
          state_d = S_FLUSH;
        end
`endif
      end
      S_READ: begin
        if (all_valid) begin
          row_d = row_q + cnt_w'(1);
          if (row_q == len_q - cnt_w'(1)) state_d = S_DONE;
        end else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
`ifdef DRAIN_REPLAY_EN
      S_FLUSH: state_d = (len_q == '0) ? S_DONE : S_READ;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      row_q   <= row_d;
      base_q  <= base_d;
      stall_q <= stall_d;
    end
  end

  // FIFO data is combinational from its read pointer, so the write and the pop share an edge.
  always_comb begin
    fifo_rd   = (state_q == S_READ) && all_valid;
    sram_cen  = !fifo_rd;
    sram_wen  = !fifo_rd;
    sram_addr = base_q + addr_w'(row_q);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    stall_cnt = stall_q;
`ifdef DRAIN_REPLAY_EN
    fifo_flush = (state_q == S_FLUSH);
`else
    fifo_flush = 1'b0;
`endif
  end

endmodule
